pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline (IF/ID/EX/ME/WB).
- Turns the ID load-use flag, the EX branch-taken flag and the IF/ME memory busy flags into per-stage stall and clear strobes plus a PC redirect.
- Runs the post-reset init sequence, including the active-low register-file reset.
- Runs the memory-wait watchdog and the halt state.
- Sits beside the pipeline registers in the core top; has no datapath of its own beyond the PC target mux.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_cnt.sv | 16 +
 rtl/pipe_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: address width, controller state encoding and timer sizing for pipe_ctrl.
package pipe_ctrl_pkg;
    localparam int ADDR_W = 32;
    localparam int PIPE_ST_W = 3;
    typedef enum logic [PIPE_ST_W-1:0] {
        PIPE_ST_INIT,
        PIPE_ST_RUN,
        PIPE_ST_FLUSH,
        PIPE_ST_MEM_WAIT,
        PIPE_ST_HALT
    } pipe_st_e;
    // One timer serves INIT, FLUSH and MEM_WAIT, so it is sized for the longest of the three.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/pipe_ctrl_cnt.sv
// pipe_ctrl_cnt: loadable down-counter with zero flag; counts down every cycle and parks at zero.
module pipe_ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    assign o_zero = (r_cnt == '0);
    always_ff @(posedge clk) begin
        if (i_load) r_cnt <= i_val;
        else if (!o_zero) r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/sequencing controller (init, flush, memory wait watchdog, halt).
// Optional performance counters enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl import pipe_ctrl_pkg::*; #(
    parameter int                RESET_CYCLES = 4,
    parameter int                FLUSH_CYCLES = 1,
    parameter int                MEM_TIMEOUT  = 255,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_mem_hazard,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    input  logic              i_if_busy,
    input  logic              i_me_busy,
    input  logic              i_halt,
    output logic              o_if_stall,
    output logic              o_id_stall,
    output logic              o_ex_stall,
    output logic              o_me_stall,
    output logic              o_id_clr,
    output logic              o_ex_clr,
    output logic              o_me_clr,
    output logic              o_wb_clr,
    output logic              o_pc_load,
    output logic [ADDR_W-1:0] o_pc_target,
    output logic              o_rf_reset_n,
    output logic              o_halted,
    output logic              o_error
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       o_cnt_cycles,
    output logic [31:0]       o_cnt_load_stall,
    output logic [31:0]       o_cnt_flush,
    output logic [31:0]       o_cnt_mem_wait
`endif
);
    localparam int CNT_W = cnt_width(RESET_CYCLES, FLUSH_CYCLES, MEM_TIMEOUT);
    pipe_st_e         r_state, w_next;
    logic             r_error, w_timeout, w_load, w_zero;
    logic [CNT_W-1:0] w_val;

    pipe_ctrl_cnt #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .i_load (w_load),
        .i_val  (w_val),
        .o_zero (w_zero)
    );

    assign o_pc_target = (r_state == PIPE_ST_INIT) ? RESET_PC : i_branch_target;
    assign o_halted    = (r_state == PIPE_ST_HALT);
    assign o_error     = r_error | w_timeout;

    always_comb begin
        {o_if_stall, o_id_stall, o_ex_stall, o_me_stall} = '0;
        {o_id_clr, o_ex_clr, o_me_clr, o_wb_clr} = '0;
        o_pc_load = 1'b0;
        o_rf_reset_n = 1'b1;
        w_timeout = 1'b0;
        w_next = r_state;
        w_load = 1'b0;
        w_val = CNT_W'(MEM_TIMEOUT - 1);
        case (r_state)
            PIPE_ST_INIT: begin
                {o_id_clr, o_ex_clr, o_me_clr, o_wb_clr} = '1;
                o_rf_reset_n = w_zero;
                o_pc_load = w_zero;
                if (w_zero) w_next = PIPE_ST_RUN;
            end
            PIPE_ST_RUN: begin
                if (i_halt) begin
                    {o_if_stall, o_id_stall, o_ex_stall, o_me_stall} = '1;
                    w_next = PIPE_ST_HALT;
                end else if (i_me_busy) begin
                    {o_if_stall, o_id_stall, o_ex_stall, o_me_stall} = '1;
                    o_wb_clr = 1'b1;
                    w_load = 1'b1;
                    w_next = PIPE_ST_MEM_WAIT;
                end else if (i_branch_taken) begin
                    // Younger instructions are squashed, so hazard/fetch-busy are irrelevant here.
                    o_pc_load = 1'b1;
                    o_id_clr = 1'b1;
                    o_ex_clr = 1'b1;
                    if (FLUSH_CYCLES > 0) begin
                        w_load = 1'b1;
                        w_val = CNT_W'(FLUSH_CYCLES - 1);
                        w_next = PIPE_ST_FLUSH;
                    end
                end else if (i_mem_hazard) begin
                    o_if_stall = 1'b1;
                    o_id_stall = 1'b1;
                    o_ex_clr = 1'b1;
                end else if (i_if_busy) begin
                    o_if_stall = 1'b1;
                    o_id_clr = 1'b1;
                end
            end
            PIPE_ST_FLUSH: begin
                if (i_me_busy) begin
                    {o_if_stall, o_id_stall, o_ex_stall, o_me_stall} = '1;
                    o_wb_clr = 1'b1;
                    w_load = 1'b1;
                    w_next = PIPE_ST_MEM_WAIT;
                end else begin
                    o_id_clr = 1'b1;
                    if (w_zero) w_next = PIPE_ST_RUN;
                end
            end
            PIPE_ST_MEM_WAIT: begin
                if (!i_me_busy) w_next = PIPE_ST_RUN;
                else begin
                    {o_if_stall, o_id_stall, o_ex_stall, o_me_stall} = '1;
                    o_wb_clr = 1'b1;
                    if (w_zero) begin
                        w_timeout = 1'b1;
                        w_next = PIPE_ST_HALT;
                    end
                end
            end
            PIPE_ST_HALT: {o_if_stall, o_id_stall, o_ex_stall, o_me_stall} = '1;
            default: w_next = PIPE_ST_INIT;
        endcase
        if (clr) begin
            w_load = 1'b1;
            w_val = CNT_W'(RESET_CYCLES - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= PIPE_ST_INIT;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_error <= r_error | w_timeout;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic w_active, w_redirect, w_load_stall, w_wait;
    assign w_active     = r_state inside {PIPE_ST_RUN, PIPE_ST_FLUSH, PIPE_ST_MEM_WAIT};
    assign w_redirect   = (r_state == PIPE_ST_RUN) && o_pc_load;
    // In RUN, an ID stall without an ME stall can only come from a load-use hazard.
    assign w_load_stall = (r_state == PIPE_ST_RUN) && o_id_stall && !o_me_stall;
    assign w_wait       = (r_state == PIPE_ST_MEM_WAIT);
    always_ff @(posedge clk) begin
        if (clr) begin
            o_cnt_cycles <= '0;
            o_cnt_load_stall <= '0;
            o_cnt_flush <= '0;
            o_cnt_mem_wait <= '0;
        end else begin
            o_cnt_cycles <= o_cnt_cycles + 32'(w_active && (o_cnt_cycles != '1));
            o_cnt_load_stall <= o_cnt_load_stall + 32'(w_load_stall && (o_cnt_load_stall != '1));
            o_cnt_flush <= o_cnt_flush + 32'(w_redirect && (o_cnt_flush != '1));
            o_cnt_mem_wait <= o_cnt_mem_wait + 32'(w_wait && (o_cnt_mem_wait != '1));
        end
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus random stimulus for pipe_ctrl checked against a behavioural model.
module tb_pipe_ctrl;
    localparam int RC = 4;
    localparam int FC = 1;
    localparam int MT = 5;

    logic        clk = 1'b0;
    logic        clr, i_mem_hazard, i_branch_taken, i_if_busy, i_me_busy, i_halt;
    logic [31:0] i_branch_target, o_pc_target;
    logic        o_if_stall, o_id_stall, o_ex_stall, o_me_stall;
    logic        o_id_clr, o_ex_clr, o_me_clr, o_wb_clr;
    logic        o_pc_load, o_rf_reset_n, o_halted, o_error;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] o_cnt_cycles, o_cnt_load_stall, o_cnt_flush, o_cnt_mem_wait;
`endif

    int errors = 0;
    int checks = 0;

    // Model: remaining INIT cycles, remaining FLUSH cycles, busy cycles seen in the current wait.
    int m_init = 0, m_flush = 0, m_busyn = 0;
    bit m_wait = 0, m_halt = 0, m_err = 0, m_valid = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.RESET_CYCLES(RC), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .clr             (clr),
        .i_mem_hazard    (i_mem_hazard),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_if_busy       (i_if_busy),
        .i_me_busy       (i_me_busy),
        .i_halt          (i_halt),
        .o_if_stall      (o_if_stall),
        .o_id_stall      (o_id_stall),
        .o_ex_stall      (o_ex_stall),
        .o_me_stall      (o_me_stall),
        .o_id_clr        (o_id_clr),
        .o_ex_clr        (o_ex_clr),
        .o_me_clr        (o_me_clr),
        .o_wb_clr        (o_wb_clr),
        .o_pc_load       (o_pc_load),
        .o_pc_target     (o_pc_target),
        .o_rf_reset_n    (o_rf_reset_n),
        .o_halted        (o_halted),
        .o_error         (o_error)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .o_cnt_cycles     (o_cnt_cycles),
        .o_cnt_load_stall (o_cnt_load_stall),
        .o_cnt_flush      (o_cnt_flush),
        .o_cnt_mem_wait   (o_cnt_mem_wait)
`endif
    );

    // vector: [11:8] if/id/ex/me stall, [7:4] id/ex/me/wb clr, [3] pc_load, [2] rf_reset_n, [1] halted, [0] error
    task automatic cyc(input string tag, input bit c, input bit hz, input bit br, input logic [31:0] tg,
                       input bit ifb, input bit meb, input bit hl);
        logic [11:0] e, got;
        logic [31:0] et;
        bit to;
        clr = c; i_mem_hazard = hz; i_branch_taken = br; i_branch_target = tg;
        i_if_busy = ifb; i_me_busy = meb; i_halt = hl;
        @(negedge clk);
        e = 12'b0000_0000_0100;
        et = tg;
        to = 0;
        if (m_init > 0) begin
            e[7:4] = 4'hF;
            e[3] = (m_init == 1);
            e[2] = (m_init == 1);
            et = 32'h0;
            m_init--;
        end else if (m_halt) begin
            e[11:8] = 4'hF;
            e[1] = 1;
        end else if (m_wait) begin
            if (!meb) m_wait = 0;
            else begin
                m_busyn++;
                e[11:8] = 4'hF;
                e[4] = 1;
                if (m_busyn == MT + 1) begin
                    to = 1; m_wait = 0; m_halt = 1;
                end
            end
        end else if (m_flush > 0) begin
            if (meb) begin
                e[11:8] = 4'hF; e[4] = 1;
                m_wait = 1; m_busyn = 1; m_flush = 0;
            end else begin
                e[7] = 1;
                m_flush--;
            end
        end else if (hl) begin
            e[11:8] = 4'hF;
            m_halt = 1;
        end else if (meb) begin
            e[11:8] = 4'hF; e[4] = 1;
            m_wait = 1; m_busyn = 1;
        end else if (br) begin
            e[3] = 1; e[7] = 1; e[6] = 1;
            m_flush = FC;
        end else if (hz) begin
            e[11] = 1; e[10] = 1; e[6] = 1;
        end else if (ifb) begin
            e[11] = 1; e[7] = 1;
        end
        e[0] = m_err | to;
        m_err = m_err | to;
        got = {o_if_stall, o_id_stall, o_ex_stall, o_me_stall, o_id_clr, o_ex_clr, o_me_clr, o_wb_clr,
               o_pc_load, o_rf_reset_n, o_halted, o_error};
        if (m_valid) begin
            checks++;
            assert (got === e) else begin
                errors++;
                $error("FAIL %s strobes got=%b exp=%b", tag, got, e);
            end
            checks++;
            assert (o_pc_target === et) else begin
                errors++;
                $error("FAIL %s pc_target got=%h exp=%h", tag, o_pc_target, et);
            end
        end
        @(posedge clk);
        if (c) begin
            m_init = RC; m_flush = 0; m_wait = 0; m_halt = 0; m_err = 0; m_busyn = 0; m_valid = 1;
        end
        #1;
    endtask

    initial begin
        bit c, hz, br, ifb, meb, hl;
        clr = 1; i_mem_hazard = 0; i_branch_taken = 0; i_branch_target = 0;
        i_if_busy = 0; i_me_busy = 0; i_halt = 0;
        @(posedge clk);
        #1;
        cyc("clr0", 1, 0, 0, 32'h0, 0, 0, 0);
        cyc("clr1", 1, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < RC; i++) cyc("init", 0, 0, 0, $urandom, 0, 0, 0);
        cyc("idle", 0, 0, 0, 32'h10, 0, 0, 0);
        cyc("hazard", 0, 1, 0, 32'h10, 0, 0, 0);
        cyc("post_hazard", 0, 0, 0, 32'h10, 0, 0, 0);
        cyc("branch", 0, 1, 1, 32'h40, 1, 0, 0);
        cyc("flush", 0, 0, 0, 32'h44, 0, 0, 0);
        cyc("post_flush", 0, 0, 0, 32'h48, 0, 0, 0);
        cyc("if_busy", 0, 0, 0, 32'h48, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc("busy_br", 0, 0, 1, 32'h80, 0, 1, 0);
        cyc("release", 0, 0, 1, 32'h80, 0, 0, 0);
        cyc("late_br", 0, 0, 1, 32'h80, 0, 0, 0);
        cyc("flush2", 0, 0, 0, 32'h84, 0, 0, 0);
        cyc("br_pre", 0, 0, 1, 32'hC0, 0, 0, 0);
        cyc("flush_busy", 0, 0, 0, 32'hC4, 0, 1, 0);
        cyc("wait_rel", 0, 0, 0, 32'hC4, 0, 0, 0);
        for (int i = 0; i < MT + 1; i++) cyc("timeout", 0, 0, 0, 32'h100, 0, 1, 0);
        cyc("halt_err", 0, 0, 1, 32'h104, 0, 1, 0);
        cyc("clr_err", 1, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < RC; i++) cyc("reinit", 0, 0, 0, $urandom, 0, 0, 0);
        cyc("halt_req", 0, 0, 1, 32'h200, 0, 1, 1);
        cyc("halted_br", 0, 1, 1, 32'h204, 1, 1, 0);
        cyc("halted_idle", 0, 0, 0, 32'h208, 0, 0, 0);
        cyc("clr_halt", 1, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < RC; i++) cyc("init3", 0, 0, 0, $urandom, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            c = ($urandom_range(0, 39) == 0);
            hz = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 4) == 0);
            ifb = ($urandom_range(0, 3) == 0);
            meb = ($urandom_range(0, 2) != 0);
            hl = ($urandom_range(0, 59) == 0);
            cyc("random", c, hz, br, $urandom, ifb, meb, hl);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
